// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle engine for a multiplexed address/data RTC: address phase, gap, data phase, done strobe.
// Optional one-deep command queue enabled by defining RTC_BUS_PENDING_EN.
module rtc_bus_ctrl #(
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SETUP, S_A_PULSE, S_A_HOLD, S_GAP,
    S_D_SETUP, S_D_PULSE, S_D_HOLD, S_DONE
  } state_e;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
    logic       oe;
    logic [7:0] dout;
  } bus_t;

  localparam logic [3:0] C_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] C_PULSE = 4'(T_PULSE - 1);
  localparam logic [3:0] C_HOLD  = 4'(T_HOLD - 1);
  localparam logic [3:0] C_GAP   = 4'(T_GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  bus_t       bus_d;

`ifdef RTC_BUS_PENDING_EN
  logic       pend_vld_q, pend_vld_d;
  logic       pend_rw_q, pend_rw_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_wdata_q, pend_wdata_d;
`endif

  // Counter preload on entry: a state lasting N cycles counts N-1 down to 0.
  function automatic logic [3:0] load_cnt(input state_e s);
    case (s)
      S_A_SETUP, S_D_SETUP: load_cnt = C_SETUP;
      S_A_PULSE, S_D_PULSE: load_cnt = C_PULSE;
      S_A_HOLD,  S_D_HOLD:  load_cnt = C_HOLD;
      S_GAP:                load_cnt = C_GAP;
      default:              load_cnt = 4'd0;
    endcase
  endfunction

  function automatic state_e next_timed(input state_e s);
    case (s)
      S_A_SETUP: next_timed = S_A_PULSE;
      S_A_PULSE: next_timed = S_A_HOLD;
      S_A_HOLD:  next_timed = S_GAP;
      S_GAP:     next_timed = S_D_SETUP;
      S_D_SETUP: next_timed = S_D_PULSE;
      S_D_PULSE: next_timed = S_D_HOLD;
      S_D_HOLD:  next_timed = S_DONE;
      default:   next_timed = S_IDLE;
    endcase
  endfunction

  function automatic bus_t bus_decode(input state_e s, input logic w,
                                      input logic [7:0] a, input logic [7:0] d);
    bus_t b;
    b.cs_n = 1'b1;
    b.rd_n = 1'b1;
    b.wr_n = 1'b1;
    b.ad   = 1'b0;
    b.oe   = 1'b0;
    b.dout = 8'h00;
    case (s)
      S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
        b.cs_n = 1'b0;
        b.oe   = 1'b1;
        b.dout = a;
        b.wr_n = (s != S_A_PULSE);
      end
      S_GAP: begin
        b.oe   = 1'b1;
        b.dout = a;
      end
      S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
        b.cs_n = 1'b0;
        b.ad   = 1'b1;
        b.oe   = w;
        b.dout = w ? d : 8'h00;
        b.wr_n = !(w && s == S_D_PULSE);
        b.rd_n = !(!w && s == S_D_PULSE);
      end
      default: ;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef RTC_BUS_PENDING_EN
    pend_vld_d   = pend_vld_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_A_SETUP;
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef RTC_BUS_PENDING_EN
        // A queued command chains straight into the next address phase.
        if (pend_vld_q) begin
          state_d    = S_A_SETUP;
          rw_d       = pend_rw_q;
          addr_d     = pend_addr_q;
          wdata_d    = pend_wdata_q;
          pend_vld_d = 1'b0;
        end else if (start) begin
          state_d = S_A_SETUP;
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
        end
`endif
      end
      default: begin
        if (cnt_q == 4'd0) state_d = next_timed(state_q);
        else               cnt_d   = cnt_q - 4'd1;
      end
    endcase
    if (state_d != state_q) cnt_d = load_cnt(state_d);
`ifdef RTC_BUS_PENDING_EN
    if (start && !pend_vld_q && state_q != S_IDLE && state_q != S_DONE) begin
      pend_vld_d   = 1'b1;
      pend_rw_d    = rw;
      pend_addr_d  = addr;
      pend_wdata_d = wdata;
    end
`endif
  end

  // Outputs are decoded from the next state so every pad is a flop.
  assign bus_d = bus_decode(state_d, rw_d, addr_d, wdata_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad      <= 1'b0;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
`ifdef RTC_BUS_PENDING_EN
      pend_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
      cs_n    <= bus_d.cs_n;
      rd_n    <= bus_d.rd_n;
      wr_n    <= bus_d.wr_n;
      ad      <= bus_d.ad;
      ad_oe   <= bus_d.oe;
      ad_out  <= bus_d.dout;
      // Read data is taken on the edge that releases rd_n.
      if (state_q == S_D_PULSE && cnt_q == 4'd0 && !rw_q) rdata <= ad_in;
`ifdef RTC_BUS_PENDING_EN
      pend_vld_q <= pend_vld_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
`ifdef RTC_BUS_PENDING_EN
    pend_rw_q    <= pend_rw_d;
    pend_addr_q  <= pend_addr_d;
    pend_wdata_q <= pend_wdata_d;
`endif
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: default-timing instance plus a (2,1,3,1) timing instance.
module tb_rtc_bus_ctrl;
  logic       clk = 1'b0;
  logic       reset, start, start2, rw;
  logic [7:0] addr, wdata, rd_val;

  logic       busy1, done1, cs1, rd1, wr1, ad1, oe1;
  logic [7:0] rdata1, adout1, adin1;
  logic       busy2, done2, cs2, rd2, wr2, ad2, oe2;
  logic [7:0] rdata2, adout2, adin2;

  // RTC model: drives read data only while rd_n is low.
  assign adin1 = rd1 ? 8'hEE : rd_val;
  assign adin2 = rd2 ? 8'hEE : rd_val;

  rtc_bus_ctrl dut1 (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .cs_n(cs1), .rd_n(rd1), .wr_n(wr1),
    .ad(ad1), .ad_out(adout1), .ad_oe(oe1), .ad_in(adin1)
  );

  rtc_bus_ctrl #(.T_SETUP(2), .T_PULSE(1), .T_HOLD(3), .T_GAP(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .cs_n(cs2), .rd_n(rd2), .wr_n(wr2),
    .ad(ad2), .ad_out(adout2), .ad_oe(oe2), .ad_in(adin2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int use2, stop_at, chg_at;
  logic chg_pulse, chg_rw;
  logic [7:0] chg_addr, chg_wdata;

  logic       s_cs[64], s_rd[64], s_wr[64], s_ad[64], s_oe[64], s_done[64], s_busy[64];
  logic [7:0] s_out[64], s_rdat[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle k is the clock period following the k-th edge after the one that samples start.
  task automatic run(input int n);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (use2 != 0) begin
        s_cs[k] = cs2; s_rd[k] = rd2; s_wr[k] = wr2; s_ad[k] = ad2; s_oe[k] = oe2;
        s_done[k] = done2; s_busy[k] = busy2; s_out[k] = adout2; s_rdat[k] = rdata2;
      end else begin
        s_cs[k] = cs1; s_rd[k] = rd1; s_wr[k] = wr1; s_ad[k] = ad1; s_oe[k] = oe1;
        s_done[k] = done1; s_busy[k] = busy1; s_out[k] = adout1; s_rdat[k] = rdata1;
      end
      if (k == stop_at) begin start = 1'b0; start2 = 1'b0; end
      if (k == chg_at) begin rw = chg_rw; addr = chg_addr; wdata = chg_wdata; start = 1'b1; end
      if (chg_pulse && k == chg_at + 1) start = 1'b0;
    end
  endtask

  task automatic go(input logic w, input logic [7:0] a, input logic [7:0] d,
                    input int n, input int stop);
    rw = w; addr = a; wdata = d; stop_at = stop;
    if (use2 != 0) start2 = 1'b1;
    else           start  = 1'b1;
    run(n);
  endtask

  function automatic int cnt(input int lo, input int hi, input int sel);
    int c = 0;
    for (int k = lo; k <= hi; k++) begin
      logic hit;
      case (sel)
        0:  hit = !s_cs[k] && !s_ad[k];
        1:  hit = !s_wr[k] && !s_ad[k];
        2:  hit = !s_cs[k] && s_ad[k];
        3:  hit = !s_wr[k] && s_ad[k];
        4:  hit = !s_rd[k];
        5:  hit = s_done[k];
        6:  hit = s_busy[k];
        7:  hit = s_cs[k] && s_busy[k] && !s_done[k];
        8:  hit = (!s_rd[k] && !s_wr[k]) || ((!s_rd[k] || !s_wr[k]) && s_cs[k]);
        9:  hit = s_oe[k] && !s_cs[k] && s_ad[k];
        10: hit = !s_wr[k];
        default: hit = !s_cs[k];
      endcase
      if (hit) c++;
    end
    return c;
  endfunction

  function automatic int first_done(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (s_done[k]) return k;
    return -1;
  endfunction

  function automatic int bad_out(input int lo, input int hi, input logic adsel, input logic [7:0] v);
    int c = 0;
    for (int k = lo; k <= hi; k++)
      if (!s_cs[k] && s_ad[k] == adsel && s_out[k] !== v) c++;
    return c;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
    rd_val = 8'h00; use2 = 0; stop_at = -1; chg_at = -1; chg_pulse = 1'b0;
    chg_rw = 1'b0; chg_addr = 8'h00; chg_wdata = 8'h00;

    #12;
    chk("rst_ctrl", {cs1, rd1, wr1, ad1, oe1, busy1, done1}, 7'b1110000);
    chk("rst_data", {adout1, rdata1}, 16'h0000);
    chk("rst_ctrl2", {cs2, rd2, wr2, ad2, oe2, busy2, done2}, 7'b1110000);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Write 21 <- 59
    go(1'b1, 8'h21, 8'h59, 20, 1);
    chk("wr_cs_addr", cnt(1, 20, 0), 6);
    chk("wr_wr_addr", cnt(1, 20, 1), 4);
    chk("wr_gap", cnt(1, 20, 7), 2);
    chk("wr_cs_data", cnt(1, 20, 2), 6);
    chk("wr_wr_data", cnt(1, 20, 3), 4);
    chk("wr_rd_none", cnt(1, 20, 4), 0);
    chk("wr_out_addr", bad_out(1, 20, 1'b0, 8'h21), 0);
    chk("wr_out_data", bad_out(1, 20, 1'b1, 8'h59), 0);
    chk("wr_out_gap", {s_oe[7], s_out[7], s_oe[8], s_out[8]}, {1'b1, 8'h21, 1'b1, 8'h21});
    chk("wr_done_cyc", first_done(1, 20), 15);
    chk("wr_done_cnt", cnt(1, 20, 5), 1);
    chk("wr_busy_cnt", cnt(1, 20, 6), 15);
    chk("wr_overlap", cnt(1, 20, 8), 0);
    chk("wr_rdata_kept", s_rdat[15], 8'h00);

    // Read 22 -> 37
    rd_val = 8'h37;
    go(1'b0, 8'h22, 8'h00, 20, 1);
    chk("rd_rd_low", cnt(1, 20, 4), 4);
    chk("rd_wr_addr", cnt(1, 20, 1), 4);
    chk("rd_wr_data", cnt(1, 20, 3), 0);
    chk("rd_oe_data", cnt(1, 20, 9), 0);
    chk("rd_out_addr", bad_out(1, 20, 1'b0, 8'h22), 0);
    chk("rd_done_cyc", first_done(1, 20), 15);
    chk("rd_rdata_early", s_rdat[13], 8'h00);
    chk("rd_rdata_done", s_rdat[15], 8'h37);
    chk("rd_overlap", cnt(1, 20, 8), 0);

    // Reset in the middle of the address strobe
    rw = 1'b1; addr = 8'h30; wdata = 8'h31; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_wr_low", {cs1, wr1}, 2'b00);
    reset = 1'b0;
    #1;
    chk("mid_rst_ctrl", {cs1, rd1, wr1, ad1, oe1, busy1, done1}, 7'b1110000);
    chk("mid_rst_data", {adout1, rdata1}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_hold", {cs1, wr1, busy1}, 3'b110);
    reset = 1'b1;
    @(negedge clk);
    stop_at = -1;
    run(20);
    chk("mid_no_done", cnt(1, 20, 5), 0);
    chk("mid_no_cs", cnt(1, 20, 11), 0);

`ifndef RTC_BUS_PENDING_EN
    // start held high: second command only once IDLE is re-entered
    chg_at = 3; chg_pulse = 1'b0; chg_rw = 1'b1; chg_addr = 8'h40; chg_wdata = 8'hA5;
    go(1'b1, 8'h40, 8'h5A, 34, 20);
    chg_at = -1;
    chk("hold_done1", first_done(1, 20), 15);
    chk("hold_cs_one", cnt(1, 16, 11), 12);
    chk("hold_data1", {s_wr[10], s_ad[10], s_out[10]}, {1'b0, 1'b1, 8'h5A});
    chk("hold_idle", s_busy[16], 1'b0);
    chk("hold_second", {s_cs[17], s_busy[17]}, 2'b01);
    chk("hold_data2", {s_wr[26], s_ad[26], s_out[26]}, {1'b0, 1'b1, 8'hA5});
    chk("hold_done2", first_done(17, 34), 31);
    chk("hold_done_cnt", cnt(1, 34, 5), 2);
`else
    // Queued read behind a write
    rd_val = 8'h3C;
    chg_at = 3; chg_pulse = 1'b1; chg_rw = 1'b0; chg_addr = 8'h11; chg_wdata = 8'h00;
    go(1'b1, 8'h10, 8'h4C, 34, 1);
    chg_at = -1; chg_pulse = 1'b0;
    chk("q_done1", first_done(1, 34), 15);
    chk("q_done2", first_done(16, 34), 30);
    chk("q_done_cnt", cnt(1, 34, 5), 2);
    chk("q_busy_run", cnt(1, 30, 6), 30);
    chk("q_busy_end", s_busy[31], 1'b0);
    chk("q_rd_low", cnt(16, 30, 4), 4);
    chk("q_out_addr2", bad_out(16, 30, 1'b0, 8'h11), 0);
    chk("q_rdata", s_rdat[30], 8'h3C);
    chk("q_overlap", cnt(1, 34, 8), 0);
`endif

    // Alternate timing instance: setup 2, pulse 1, hold 3, gap 1
    use2 = 1;
    go(1'b1, 8'h33, 8'h44, 18, 1);
    chk("t6_done_cyc", first_done(1, 18), 14);
    chk("t6_wr_addr", cnt(1, 18, 1), 1);
    chk("t6_wr_data", cnt(1, 18, 3), 1);
    chk("t6_cs_low", cnt(1, 18, 11), 12);
    chk("t6_gap", cnt(1, 18, 7), 1);
    chk("t6_busy", cnt(1, 18, 6), 14);
    chk("t6_overlap", cnt(1, 18, 8), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
